tpu_mmu_ctrl: RTL and testbench

Sequencer for one matrix-multiply pass on the TPU datapath. Drives the weight FIFO's `en`, the systolic array's `wwrite`/`active`, and the activation memory's per-row `rd_en`/`rd_addr`, so that a weight tile is loaded and latched and then `num_rows` activation vectors are streamed through the array with diagonal skew. Sits between the host/command interface and the weightFifo / sysArr / memArr trio.

---
 rtl/tpu_mmu_ctrl_pkg.sv | 37 +++
 rtl/tpu_mmu_ctrl_rd_skew.sv | 59 +++++
 rtl/tpu_mmu_ctrl.sv | 158 +++++++++++++++
 tb/tb_tpu_mmu_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tpu_mmu_ctrl_pkg.sv
// Package tpu_ctrl_pkg: shared types and phase-length helpers for the
// matrix-multiply pass sequencer (tpu_mmu_ctrl) and its read-skew helper.
//   mmu_ctrl_state_t : sequencer phase encoding
//   load_cyc/latch_cyc/drain_cyc : phase lengths as a function of array size
//   LOAD_CYC/LATCH_CYC/DRAIN_CYC : phase lengths for the default 4x4 array
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LATCH  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } mmu_ctrl_state_t;

    // One weight row per cycle fills the FIFO.
    function automatic int load_cyc(input int wh);
        return wh;
    endfunction

    // The latch phase shifts the full tile into the array.
    function automatic int latch_cyc(input int wh);
        return wh;
    endfunction

    // Partial sums need two array traversals to leave through maccout.
    function automatic int drain_cyc(input int wh);
        return 2 * wh;
    endfunction

    localparam int WH_DEFAULT = 4;
    localparam int LOAD_CYC   = WH_DEFAULT;
    localparam int LATCH_CYC  = WH_DEFAULT;
    localparam int DRAIN_CYC  = 2 * WH_DEFAULT;

endpackage

// File: rtl/tpu_mmu_ctrl_rd_skew.sv
// tpu_rd_skew: registered diagonal-skew generator for the activation memory.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   en                    : step k is a STREAM step for the coming cycle
//   k                     : stream step index for the coming cycle
//   rows                  : number of activation vectors in the pass
//   base                  : first activation address
//   rd_en   [WH-1:0]      : per-lane read enable (registered)
//   rd_addr [WH*AW-1:0]   : per-lane read address, lane r at [r*AW +: AW]
module tpu_rd_skew #(
    parameter int WIDTH_HEIGHT = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic [CNT_WIDTH:0]                 k,
    input  logic [CNT_WIDTH-1:0]               rows,
    input  logic [ADDR_WIDTH-1:0]              base,
    output logic [WIDTH_HEIGHT-1:0]            rd_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr
);

    localparam int KW = CNT_WIDTH + 1;

    logic [WIDTH_HEIGHT-1:0]            en_next;
    logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] addr_next;
    logic [KW-1:0]                      lane_k;

    // Lane r sees the activation stream delayed by r steps; idle lanes read address 0.
    always_comb begin
        en_next   = '0;
        addr_next = '0;
        lane_k    = '0;
        for (int r = 0; r < WIDTH_HEIGHT; r++) begin
            lane_k = k - KW'(r);
            if (en && (k >= KW'(r)) && (lane_k < {1'b0, rows})) begin
                en_next[r]                            = 1'b1;
                addr_next[r*ADDR_WIDTH +: ADDR_WIDTH] = base + ADDR_WIDTH'(lane_k);
            end else begin
                en_next[r]                            = 1'b0;
                addr_next[r*ADDR_WIDTH +: ADDR_WIDTH] = '0;
            end
        end
    end

    // Output registers for the memory read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en   <= '0;
            rd_addr <= '0;
        end else begin
            rd_en   <= en_next;
            rd_addr <= addr_next;
        end
    end

endmodule

// File: rtl/tpu_mmu_ctrl.sv
// tpu_mmu_ctrl: sequencer for one matrix-multiply pass
// (LOAD -> LATCH -> STREAM -> DRAIN -> DONE).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : command strobe, honoured only when idle
//   base_addr, num_rows : pass parameters, captured on an accepted start
//   busy, done          : pass in progress / one-cycle end-of-pass pulse
//   fifo_en             : weightFifo enable
//   wwrite, active      : sysArr weight-latch and compute controls
//   rd_en, rd_addr      : memArr per-lane read enables and addresses
// Every output is a flop; the next-state decode drives their D inputs.
module tpu_mmu_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [CNT_WIDTH-1:0]               num_rows,
    output logic                               busy,
    output logic                               done,
    output logic                               fifo_en,
    output logic [WIDTH_HEIGHT-1:0]            wwrite,
    output logic                               active,
    output logic [WIDTH_HEIGHT-1:0]            rd_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr
);

    // One spare bit so num_rows at its maximum plus the skew tail cannot overflow.
    localparam int KW = CNT_WIDTH + 1;
    localparam logic [KW-1:0] LOAD_LAST  = KW'(load_cyc(WIDTH_HEIGHT) - 1);
    localparam logic [KW-1:0] LATCH_LAST = KW'(latch_cyc(WIDTH_HEIGHT) - 1);
    localparam logic [KW-1:0] DRAIN_LAST = KW'(drain_cyc(WIDTH_HEIGHT) - 1);
    localparam logic [KW-1:0] SKEW_LAST  = KW'(WIDTH_HEIGHT - 2);

    mmu_ctrl_state_t         state_r, state_next;
    logic [KW-1:0]           cnt_r, cnt_next;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [CNT_WIDTH-1:0]    rows_r;
    logic                    capture;
    logic [KW-1:0]           stream_last;

    // STREAM runs num_rows + WIDTH_HEIGHT - 1 steps, so its last index is rows + WH - 2.
    assign stream_last = {1'b0, rows_r} + SKEW_LAST;

    // Next-state and step-counter decode.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        capture    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    capture = 1'b1;
                    if (num_rows == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (cnt_r == LOAD_LAST) begin
                    state_next = LATCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_r + KW'(1'b1);
                end
            end
            LATCH: begin
                if (cnt_r == LATCH_LAST) begin
                    state_next = STREAM;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_r + KW'(1'b1);
                end
            end
            STREAM: begin
                if (cnt_r == stream_last) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_r + KW'(1'b1);
                end
            end
            DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_r + KW'(1'b1);
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter, captured command and the phase-decoded output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            base_r  <= '0;
            rows_r  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fifo_en <= 1'b0;
            wwrite  <= '0;
            active  <= 1'b0;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            if (capture) begin
                base_r <= base_addr;
                rows_r <= num_rows;
            end else begin
                base_r <= base_r;
                rows_r <= rows_r;
            end
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);
            fifo_en <= (state_next == LOAD) || (state_next == LATCH);
            wwrite  <= (state_next == LATCH) ? '1 : '0;
            active  <= (state_next == STREAM) || (state_next == DRAIN);
        end
    end

    // The skew block registers its outputs, so feed it the step of the coming cycle.
    tpu_rd_skew #(
        .WIDTH_HEIGHT (WIDTH_HEIGHT),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_rd_skew (
        .clk     (clk),
        .reset   (reset),
        .en      (state_next == STREAM),
        .k       (cnt_next),
        .rows    (rows_r),
        .base    (base_r),
        .rd_en   (rd_en),
        .rd_addr (rd_addr)
    );

endmodule

// File: tb/tb_tpu_mmu_ctrl.sv
// Bench for tpu_mmu_ctrl (4x4 array, 8-bit addresses and row count).
// A pass model predicts outputs from the cycle offset since the accepted start;
// directed passes add hand-computed literal checks.
module tb_tpu_mmu_ctrl;

    localparam int WH = 4;
    localparam int AW = 8;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [CW-1:0]     num_rows;
    logic              busy, done, fifo_en, active;
    logic [WH-1:0]     wwrite, rd_en;
    logic [WH*AW-1:0]  rd_addr;

    int n_cmp = 0;
    int n_bad = 0;

    tpu_mmu_ctrl #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .busy(busy), .done(done), .fifo_en(fifo_en),
        .wwrite(wwrite), .active(active), .rd_en(rd_en), .rd_addr(rd_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Pass length from first busy cycle to done inclusive.
    function automatic int pass_len(input int n);
        return (n == 0) ? 1 : 5 * WH + n;
    endfunction

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          t0 = 0;
    bit          pass_v = 1'b0;
    int          m_n = 0;
    int          m_b = 0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            pass_v <= 1'b0;
            chk_en <= 1'b1;
        end else if ((!pass_v || (cyc - t0) >= pass_len(m_n) + 1) && start) begin
            pass_v <= 1'b1;
            t0     <= cyc;
            m_n    <= int'(num_rows);
            m_b    <= int'(base_addr);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int o, k, L;
        logic e_busy, e_done, e_fifo, e_act;
        logic [WH-1:0] e_ww, e_en;
        logic [WH*AW-1:0] e_addr;
        e_busy = 1'b0; e_done = 1'b0; e_fifo = 1'b0; e_act = 1'b0;
        e_ww = '0; e_en = '0; e_addr = '0;
        o = cyc - t0;
        L = pass_len(m_n);
        if (pass_v && o >= 1 && o <= L) begin
            e_busy = 1'b1;
            if (m_n == 0 || o == L) begin
                e_done = 1'b1;
            end else if (o <= WH) begin
                e_fifo = 1'b1;
            end else if (o <= 2 * WH) begin
                e_fifo = 1'b1;
                e_ww = '1;
            end else begin
                e_act = 1'b1;
                k = o - 2 * WH - 1;
                for (int r = 0; r < WH; r++) begin
                    if (k >= r && k < r + m_n) begin
                        e_en[r] = 1'b1;
                        e_addr[r*AW +: AW] = AW'(m_b + k - r);
                    end
                end
            end
        end
        if (chk_en) begin
            chk("busy",    32'(busy),    32'(e_busy));
            chk("done",    32'(done),    32'(e_done));
            chk("fifo_en", 32'(fifo_en), 32'(e_fifo));
            chk("wwrite",  32'(wwrite),  32'(e_ww));
            chk("active",  32'(active),  32'(e_act));
            chk("rd_en",   32'(rd_en),   32'(e_en));
            chk("rd_addr", 32'(rd_addr), 32'(e_addr));
        end
    end

    // ---------------- directed passes ----------------
    // mode: 0 plain, 1 base 0x10/N=2 literals, 2 wrap literals,
    //       3 start re-pulse during STREAM, 4 reset at STREAM k=2, 5 N=0 literals
    task automatic run_pass(input logic [7:0] b, input logic [7:0] n, input int mode);
        int L;
        L = pass_len(int'(n));
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_rows = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'h00; num_rows = 8'h00;
        for (int o = 1; o <= L; o++) begin
            if (o > 1) begin
                @(posedge clk); #1;
            end
            case (mode)
                1: begin
                    if (o == 1)  chk("lit fifo_en o1", 32'(fifo_en), 32'd1);
                    if (o == 8)  chk("lit fifo_en o8", 32'(fifo_en), 32'd1);
                    if (o == 9)  chk("lit fifo_en o9", 32'(fifo_en), 32'd0);
                    if (o == 4)  chk("lit wwrite o4", 32'(wwrite), 32'h0);
                    if (o == 5)  chk("lit wwrite o5", 32'(wwrite), 32'hF);
                    if (o == 9)  chk("lit rd_en k0", 32'(rd_en), 32'b0001);
                    if (o == 10) chk("lit rd_en k1", 32'(rd_en), 32'b0011);
                    if (o == 11) chk("lit rd_en k2", 32'(rd_en), 32'b0110);
                    if (o == 12) chk("lit rd_en k3", 32'(rd_en), 32'b1100);
                    if (o == 13) chk("lit rd_en k4", 32'(rd_en), 32'b1000);
                    if (o == 14) chk("lit rd_en drain", 32'(rd_en), 32'b0000);
                    if (o == 9)  chk("lit lane0 k0", 32'(rd_addr[7:0]), 32'h10);
                    if (o == 10) chk("lit lane0 k1", 32'(rd_addr[7:0]), 32'h11);
                    if (o == 12) chk("lit lane3 k3", 32'(rd_addr[31:24]), 32'h10);
                    if (o == 13) chk("lit lane3 k4", 32'(rd_addr[31:24]), 32'h11);
                    if (o == 21) chk("lit done o21", 32'(done), 32'd0);
                    if (o == 22) chk("lit done o22", 32'(done), 32'd1);
                end
                2: begin
                    if (o == 9)  chk("lit wrap k0", 32'(rd_addr[7:0]), 32'hFE);
                    if (o == 10) chk("lit wrap k1", 32'(rd_addr[7:0]), 32'hFF);
                    if (o == 11) chk("lit wrap k2", 32'(rd_addr[7:0]), 32'h00);
                    if (o == 12) chk("lit wrap k3", 32'(rd_addr[7:0]), 32'h01);
                end
                3: begin
                    if (o == 10) begin
                        start = 1'b1; base_addr = 8'h99; num_rows = 8'h07;
                    end
                    if (o == 11) begin
                        start = 1'b0; base_addr = 8'h00; num_rows = 8'h00;
                    end
                    if (o == 23) chk("lit done repulse", 32'(done), 32'd1);
                end
                4: begin
                    if (o == 11) begin
                        chk("lit rd_en pre-reset", 32'(rd_en), 32'b0111);
                        reset = 1'b1;
                        @(posedge clk); #1;
                        reset = 1'b0;
                        chk("lit busy after reset", 32'(busy), 32'd0);
                        chk("lit rd_en after reset", 32'(rd_en), 32'd0);
                        return;
                    end
                end
                5: begin
                    if (o == 1) begin
                        chk("lit zero busy", 32'(busy), 32'd1);
                        chk("lit zero done", 32'(done), 32'd1);
                        chk("lit zero fifo_en", 32'(fifo_en), 32'd0);
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 8'h00; num_rows = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("lit idle busy", 32'(busy), 32'd0);

        run_pass(8'h10, 8'd2, 1);
        run_pass(8'hFE, 8'd4, 2);
        run_pass(8'h33, 8'd0, 5);
        @(posedge clk); #1 chk("lit zero busy after", 32'(busy), 32'd0);
        run_pass(8'h20, 8'd3, 3);
        run_pass(8'h80, 8'd1, 0);      // started in the cycle after done
        run_pass(8'h05, 8'd6, 4);      // aborted by reset
        repeat (3) @(posedge clk);
        run_pass(8'h40, 8'd2, 0);
        run_pass(8'hF0, 8'd20, 0);
        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
